// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - writeback/commit unit: 2-entry in-order FIFO feeding the regfile write port and difftest PC.
// Optional feature macro: WB_DIFFTEST_EN (stores and publishes the retiring PC on pc_wb).
module wb_commit #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [XLEN-1:0]   in_data,
  input  logic              commit_hold,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic [XLEN-1:0]   wr_data_o,
  output logic [XLEN-1:0]   pc_wb,
  output logic [63:0]       instret_o,
  output logic              busy_o
);

  logic [1:0]        r_count;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [REG_AW-1:0] r_rd_q   [2];
  logic              r_we_q   [2];
  logic [XLEN-1:0]   r_data_q [2];

  logic              r_wr_en;
  logic [REG_AW-1:0] r_wr_addr;
  logic [XLEN-1:0]   r_wr_data;
  logic [63:0]       r_instret;

  logic              w_push;
  logic              w_pop;

  // Ready comes from registered occupancy only, so a pop never frees a slot in the same cycle.
  assign in_ready = (r_count != 2'd2);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_count != 2'd0) && !commit_hold;

`ifdef WB_DIFFTEST_EN
  logic [XLEN-1:0] r_pc_q [2];
  logic [XLEN-1:0] r_pc_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_pc_q[i] <= '0;
    end else if (w_push) begin
      r_pc_q[r_wr_ptr] <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_pc_wb <= '0;
    else if (w_pop) r_pc_wb <= r_pc_q[r_rd_ptr];
    else            r_pc_wb <= '0;
  end

  assign pc_wb  = r_pc_wb;
  assign busy_o = (r_count != 2'd0) || r_wr_en || (r_pc_wb != '0);

  a_pc_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
                                 (in_valid && in_ready) |-> (in_pc != '0))
    else $error("wb_commit: accepted instruction has in_pc == 0");
`else
  logic r_ret_valid;
  logic w_pc_unused;

  assign w_pc_unused = ^in_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ret_valid <= 1'b0;
    else        r_ret_valid <= w_pop;
  end

  assign pc_wb  = '0;
  assign busy_o = (r_count != 2'd0) || r_wr_en || r_ret_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_rd_q[i]   <= '0;
        r_we_q[i]   <= 1'b0;
        r_data_q[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_rd_q[r_wr_ptr]   <= in_rd;
        r_we_q[r_wr_ptr]   <= in_rd_we;
        r_data_q[r_wr_ptr] <= in_data;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // x0 writes still retire (counter, PC) but never reach the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_instret <= 64'd0;
    end else if (w_pop) begin
      r_wr_en   <= r_we_q[r_rd_ptr] && (r_rd_q[r_rd_ptr] != '0);
      r_wr_addr <= r_rd_q[r_rd_ptr];
      r_wr_data <= r_data_q[r_rd_ptr];
      r_instret <= r_instret + 64'd1;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign instret_o = r_instret;

endmodule

// File: tb/tb_wb_commit.sv
// tb/tb_wb_commit.sv - directed table-driven bench for wb_commit (expects pc_wb per WB_DIFFTEST_EN).
module tb_wb_commit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [63:0] in_data;
  logic        commit_hold;
  logic        wr_en;
  logic [4:0]  wr_addr_o;
  logic [63:0] wr_data_o;
  logic [63:0] pc_wb;
  logic [63:0] instret_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_commit #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_data(in_data),
    .commit_hold(commit_hold),
    .wr_en(wr_en), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .pc_wb(pc_wb), .instret_o(instret_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic        hold;
    logic        rdy;
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] wdata;
    logic [63:0] pcwb;
    logic [63:0] inst;
    logic        busy;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic v, logic [63:0] pc, logic [4:0] rd, logic we,
                              logic [63:0] data, logic hold, logic rdy, logic wen,
                              logic [4:0] addr, logic [63:0] wdata, logic [63:0] pcwb,
                              logic [63:0] inst, logic busy);
    vec_t r;
    r.v = v; r.pc = pc; r.rd = rd; r.we = we; r.data = data; r.hold = hold;
    r.rdy = rdy; r.wen = wen; r.addr = addr; r.wdata = wdata; r.pcwb = pcwb;
    r.inst = inst; r.busy = busy;
    return r;
  endfunction

  function automatic logic [63:0] exp_pc(logic [63:0] pc);
`ifdef WB_DIFFTEST_EN
    return pc;
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic [63:0] pc, logic [4:0] rd, logic we,
                       logic [63:0] data, logic hold);
    in_valid = v; in_pc = pc; in_rd = rd; in_rd_we = we; in_data = data;
    commit_hold = hold;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0);

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_addr", {59'd0, wr_addr_o}, 64'd0);
    chk("rst_wr_data", wr_data_o, 64'd0);
    chk("rst_pc_wb", pc_wb, 64'd0);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single write, x0 write, hold with back-pressure
    //            v  pc            rd   we  data          hold rdy wen addr wdata          pcwb          inst busy
    tbl[0]  = mk(1, 64'h80000000, 5'd5, 1, 64'hDEADBEEF, 0,   1,  0,  0,   64'h0,        64'h0,        0,   1);
    tbl[1]  = mk(0, 64'h0,        5'd0, 0, 64'h0,        0,   1,  1,  5,   64'hDEADBEEF, 64'h80000000, 1,   1);
    tbl[2]  = mk(0, 64'h0,        5'd0, 0, 64'h0,        0,   1,  0,  5,   64'hDEADBEEF, 64'h0,        1,   0);
    tbl[3]  = mk(1, 64'h80000004, 5'd0, 1, 64'h1234,     0,   1,  0,  5,   64'hDEADBEEF, 64'h0,        1,   1);
    tbl[4]  = mk(0, 64'h0,        5'd0, 0, 64'h0,        0,   1,  0,  0,   64'h1234,     64'h80000004, 2,   1);
    tbl[5]  = mk(0, 64'h0,        5'd0, 0, 64'h0,        0,   1,  0,  0,   64'h1234,     64'h0,        2,   0);
    tbl[6]  = mk(1, 64'h100,      5'd1, 1, 64'h11,       1,   1,  0,  0,   64'h1234,     64'h0,        2,   1);
    tbl[7]  = mk(1, 64'h104,      5'd2, 1, 64'h22,       1,   1,  0,  0,   64'h1234,     64'h0,        2,   1);
    tbl[8]  = mk(1, 64'h108,      5'd3, 1, 64'h33,       1,   0,  0,  0,   64'h1234,     64'h0,        2,   1);
    tbl[9]  = mk(1, 64'h108,      5'd3, 1, 64'h33,       0,   0,  1,  1,   64'h11,       64'h100,      3,   1);
    tbl[10] = mk(1, 64'h108,      5'd3, 1, 64'h33,       0,   1,  1,  2,   64'h22,       64'h104,      4,   1);
    tbl[11] = mk(0, 64'h0,        5'd0, 0, 64'h0,        0,   1,  1,  3,   64'h33,       64'h108,      5,   1);
    tbl[12] = mk(0, 64'h0,        5'd0, 0, 64'h0,        0,   1,  0,  3,   64'h33,       64'h0,        5,   0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].rd, tbl[i].we, tbl[i].data, tbl[i].hold);
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].rdy});
      step();
      chk($sformatf("v%0d_wr_en", i), {63'd0, wr_en}, {63'd0, tbl[i].wen});
      chk($sformatf("v%0d_wr_addr", i), {59'd0, wr_addr_o}, {59'd0, tbl[i].addr});
      chk($sformatf("v%0d_wr_data", i), wr_data_o, tbl[i].wdata);
      chk($sformatf("v%0d_pc_wb", i), pc_wb, exp_pc(tbl[i].pcwb));
      chk($sformatf("v%0d_instret", i), instret_o, tbl[i].inst);
      chk($sformatf("v%0d_busy", i), {63'd0, busy_o}, {63'd0, tbl[i].busy});
    end

    // Back-to-back stream of 8, one retire per cycle
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 64'h200 + 64'(4 * i), 5'(i + 1), 1'b1, 64'hA0 + 64'(i), 1'b0);
      else       drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0);
      if (i < 8) chk($sformatf("s%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
      step();
      if (i >= 1 && i <= 8) begin
        chk($sformatf("s%0d_wr_en", i), {63'd0, wr_en}, 64'd1);
        chk($sformatf("s%0d_wr_addr", i), {59'd0, wr_addr_o}, 64'(i));
        chk($sformatf("s%0d_wr_data", i), wr_data_o, 64'hA0 + 64'(i - 1));
        chk($sformatf("s%0d_pc_wb", i), pc_wb, exp_pc(64'h200 + 64'(4 * (i - 1))));
        chk($sformatf("s%0d_instret", i), instret_o, 64'(5 + i));
      end else if (i == 9) begin
        chk("s9_wr_en", {63'd0, wr_en}, 64'd0);
        chk("s9_pc_wb", pc_wb, 64'd0);
        chk("s9_instret", instret_o, 64'd13);
      end else begin
        chk("s0_wr_en", {63'd0, wr_en}, 64'd0);
      end
    end

    // Reset while the FIFO is loaded and a write is on the port
    drive(1'b1, 64'h300, 5'd4, 1'b1, 64'h44, 1'b1);
    step();
    drive(1'b1, 64'h304, 5'd5, 1'b1, 64'h55, 1'b1);
    step();
    chk("r_full_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0);
    step();
    chk("r_pre_wr_en", {63'd0, wr_en}, 64'd1);
    chk("r_pre_wr_addr", {59'd0, wr_addr_o}, 64'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("r_wr_en", {63'd0, wr_en}, 64'd0);
    chk("r_wr_addr", {59'd0, wr_addr_o}, 64'd0);
    chk("r_wr_data", wr_data_o, 64'd0);
    chk("r_pc_wb", pc_wb, 64'd0);
    chk("r_instret", instret_o, 64'd0);
    chk("r_busy", {63'd0, busy_o}, 64'd0);
    step();
    rst_n = 1'b1;
    chk("r_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("r%0d_post_wr_en", i), {63'd0, wr_en}, 64'd0);
      chk($sformatf("r%0d_post_pc_wb", i), pc_wb, 64'd0);
      chk($sformatf("r%0d_post_instret", i), instret_o, 64'd0);
      chk($sformatf("r%0d_post_busy", i), {63'd0, busy_o}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
